// File: rtl/logic_unit_pipe_if.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe_if
// Bundles the valid/ready operand bus, the result bus and the status
// outputs of logic_unit_pipe.
//   master : the side that sends operands and consumes results
//   slave  : the logic unit itself
// Signals:
//   in_valid/in_ready      operand handshake
//   in_a/in_b/in_op        operands (N bits) and 3-bit operation select
//   out_valid/out_ready    result handshake
//   out_result             N-bit result
//   out_zero/out_parity    flags that travel with the result
//   op_count               CNT_W-bit count of completed output handshakes
// ---------------------------------------------------------------------------
interface logic_unit_pipe_if #(
   parameter int N     = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_a;
   logic [N-1:0]     in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_result;
   logic             out_zero;
   logic             out_parity;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_parity, op_count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_parity, op_count
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Pipelined N-bit bitwise logic unit for the ALU datapath. Eight logic
// operations are evaluated on accepted operands, zero/parity flags are
// derived from that result, and the bundle travels through STAGES register
// stages before reaching the output. A single advance signal moves the whole
// pipe, so a stalled output freezes every stage (bubbles stay in place).
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - logic_unit_pipe_if slave: operand/result handshakes, flags and
//          the completed-operation counter
// Parameters: N (width), STAGES (1..4), CNT_W (counter width)
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int N      = 32,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic            clk,
   input  logic            rst,
   logic_unit_pipe_if.slave bus
);

   logic                       adv;
   logic [N-1:0]               f_result;
   logic                       f_zero;
   logic                       f_parity;

   logic [STAGES-1:0]          valid_q, valid_d;
   logic [STAGES-1:0][N-1:0]   result_q, result_d;
   logic [STAGES-1:0]          zero_q, zero_d;
   logic [STAGES-1:0]          parity_q, parity_d;
   logic [CNT_W-1:0]           count_q, count_d;

   // The pipe may move whenever the last stage is empty or being drained.
   // in_ready depends only on the last-stage valid and out_ready, never on
   // in_valid, so there is no combinational loop back to the producer.
   assign adv          = !valid_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready = adv;

   // Operation decode on the incoming operands; the flags are derived here
   // once and then simply carried along with the result.
   always_comb begin
      f_result = '0;
      case (bus.in_op)
         3'b000: f_result = ~bus.in_a;
         3'b001: f_result = bus.in_a & bus.in_b;
         3'b010: f_result = bus.in_a | bus.in_b;
         3'b011: f_result = bus.in_a ^ bus.in_b;
         3'b100: f_result = ~(bus.in_a & bus.in_b);
         3'b101: f_result = ~(bus.in_a | bus.in_b);
         3'b110: f_result = ~(bus.in_a ^ bus.in_b);
         3'b111: f_result = bus.in_a;
         default: f_result = '0;
      endcase
      f_zero   = (f_result == '0);
      f_parity = ^f_result;
   end

   // Next-state for the stages and the counter. Stage 0 loads in_valid as its
   // valid bit, so an idle cycle enters the pipe as a bubble; data in a
   // bubble is whatever the operand bus held and is never observed.
   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      zero_d   = zero_q;
      parity_d = parity_q;
      count_d  = count_q;
      if (adv) begin
         valid_d[0]  = bus.in_valid;
         result_d[0] = f_result;
         zero_d[0]   = f_zero;
         parity_d[0] = f_parity;
         for (int k = 1; k < STAGES; k++) begin
            valid_d[k]  = valid_q[k-1];
            result_d[k] = result_q[k-1];
            zero_d[k]   = zero_q[k-1];
            parity_d[k] = parity_q[k-1];
         end
      end
      if (valid_q[STAGES-1] && bus.out_ready) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // State registers. Reset clears payloads too so the outputs read zero
   // right after reset, not just invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         result_q <= '0;
         zero_q   <= '0;
         parity_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
         count_q  <= count_d;
      end
   end

   assign bus.out_valid  = valid_q[STAGES-1];
   assign bus.out_result = result_q[STAGES-1];
   assign bus.out_zero   = zero_q[STAGES-1];
   assign bus.out_parity = parity_q[STAGES-1];
   assign bus.op_count   = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
// Drives two instances of logic_unit_pipe in lockstep: a 32-bit two-stage
// unit and an 8-bit single-stage unit with a 4-bit counter. A reference
// model holds each pipe as an array of slots that all move when the output
// is free, and predicts in_ready, out_valid, result, flags and op_count.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

   logic clk;
   logic rst;

   logic_unit_pipe_if #(.N(32), .CNT_W(16)) bus0 ();
   logic_unit_pipe_if #(.N(8),  .CNT_W(4))  bus1 ();

   logic_unit_pipe #(.N(32), .STAGES(2), .CNT_W(16)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   logic_unit_pipe #(.N(8), .STAGES(1), .CNT_W(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stimulus for the next cycle, one entry per instance
   logic        s_valid [2];
   logic [31:0] s_a     [2];
   logic [31:0] s_b     [2];
   logic [2:0]  s_op    [2];
   logic        s_rdy   [2];

   // Model state: pipe slots, counter and accepted total per instance
   int          stg [2] = '{2, 1};
   int          wid [2] = '{32, 8};
   int          cw  [2] = '{16, 4};
   bit          mv  [2][4];
   logic [31:0] mr  [2][4];
   int          mcnt     [2];
   int          accepted [2];
   logic [31:0] seen0 [$];

   // Compare one observed value against its expectation
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Bitwise operation straight from the opcode table, trimmed to width n
   function automatic logic [31:0] refOp(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int n);
      logic [31:0] r;
      logic [31:0] mask;
      case (op)
         3'd0: r = ~a;
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a ^ b;
         3'd4: r = ~(a & b);
         3'd5: r = ~(a | b);
         3'd6: r = ~(a ^ b);
         default: r = a;
      endcase
      mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      return r & mask;
   endfunction

   task automatic sampleDut(input int d, output logic rdy, output logic ov,
                            output logic [31:0] res, output logic z, output logic p,
                            output logic [31:0] cnt);
      if (d == 0) begin
         rdy = bus0.in_ready;  ov = bus0.out_valid;  res = bus0.out_result;
         z = bus0.out_zero;    p = bus0.out_parity;  cnt = {16'd0, bus0.op_count};
      end else begin
         rdy = bus1.in_ready;  ov = bus1.out_valid;  res = {24'd0, bus1.out_result};
         z = bus1.out_zero;    p = bus1.out_parity;  cnt = {28'd0, bus1.op_count};
      end
   endtask

   task automatic modelClear();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++) begin
            mv[d][k] = 1'b0;
            mr[d][k] = '0;
         end
         mcnt[d]     = 0;
         accepted[d] = 0;
      end
   endtask

   // Drive one cycle of stimulus, check the pre-edge outputs against the
   // model, update the model, and return at the following falling edge.
   task automatic applyStimulus();
      logic        o_rdy, o_ov, o_z, o_p;
      logic [31:0] o_res, o_cnt;
      bit          ev, er;
      int          last;
      bus0.in_valid  = s_valid[0];
      bus0.in_a      = s_a[0];
      bus0.in_b      = s_b[0];
      bus0.in_op     = s_op[0];
      bus0.out_ready = s_rdy[0];
      bus1.in_valid  = s_valid[1];
      bus1.in_a      = s_a[1][7:0];
      bus1.in_b      = s_b[1][7:0];
      bus1.in_op     = s_op[1];
      bus1.out_ready = s_rdy[1];
      #1;
      for (int d = 0; d < 2; d++) begin
         last = stg[d] - 1;
         ev   = mv[d][last];
         er   = !ev || s_rdy[d];
         sampleDut(d, o_rdy, o_ov, o_res, o_z, o_p, o_cnt);
         checkOutput($sformatf("d%0d in_ready", d), {31'd0, o_rdy}, {31'd0, er});
         checkOutput($sformatf("d%0d out_valid", d), {31'd0, o_ov}, {31'd0, ev});
         if (ev) begin
            checkOutput($sformatf("d%0d out_result", d), o_res, mr[d][last]);
            checkOutput($sformatf("d%0d out_zero", d), {31'd0, o_z}, {31'd0, (mr[d][last] == 0)});
            checkOutput($sformatf("d%0d out_parity", d), {31'd0, o_p}, {31'd0, ^mr[d][last]});
         end
         checkOutput($sformatf("d%0d op_count", d), o_cnt, mcnt[d]);
         if (d == 0 && ev && s_rdy[0] && !rst) seen0.push_back(o_res);
         if (!rst && er) begin
            if (ev && s_rdy[d]) mcnt[d] = (mcnt[d] + 1) & ((1 << cw[d]) - 1);
            for (int k = 3; k > 0; k--) begin
               mv[d][k] = mv[d][k-1];
               mr[d][k] = mr[d][k-1];
            end
            mv[d][0] = s_valid[d];
            mr[d][0] = refOp(s_op[d], s_a[d], s_b[d], wid[d]);
            if (s_valid[d]) accepted[d]++;
         end
      end
      if (rst) modelClear();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic setIdle();
      for (int d = 0; d < 2; d++) begin
         s_valid[d] = 1'b0;
         s_a[d]     = $urandom;
         s_b[d]     = $urandom;
         s_op[d]    = 3'($urandom_range(0, 7));
         s_rdy[d]   = 1'b1;
      end
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, " d0 valid"},  {31'd0, bus0.out_valid}, 32'd0);
      checkOutput({tag, " d0 result"}, bus0.out_result, 32'd0);
      checkOutput({tag, " d0 zero"},   {31'd0, bus0.out_zero}, 32'd0);
      checkOutput({tag, " d0 parity"}, {31'd0, bus0.out_parity}, 32'd0);
      checkOutput({tag, " d0 count"},  {16'd0, bus0.op_count}, 32'd0);
      checkOutput({tag, " d1 valid"},  {31'd0, bus1.out_valid}, 32'd0);
      checkOutput({tag, " d1 result"}, {24'd0, bus1.out_result}, 32'd0);
      checkOutput({tag, " d1 count"},  {28'd0, bus1.op_count}, 32'd0);
   endtask

   logic [31:0] eight_exp [8] = '{32'h0F0F0F0F, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                                  32'h0FFF0FFF, 32'h000F000F, 32'hF00FF00F, 32'hF0F0F0F0};

   initial begin
      modelClear();
      setIdle();
      rst = 1'b1;
      @(negedge clk);
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      checkCleared("reset");

      // NOT then PASS on the wide unit
      seen0.delete();
      s_valid[0] = 1'b1; s_op[0] = 3'b000; s_a[0] = 32'h0000_FFFF;
      applyStimulus();
      s_op[0] = 3'b111; s_a[0] = 32'h0;
      applyStimulus();
      setIdle();
      repeat (3) applyStimulus();
      checkOutput("not_pass count", seen0.size(), 32'd2);
      if (seen0.size() == 2) begin
         checkOutput("not result", seen0[0], 32'hFFFF_0000);
         checkOutput("pass result", seen0[1], 32'h0);
      end
      checkOutput("not_pass op_count", {16'd0, bus0.op_count}, 32'd2);

      // All eight ops back to back
      seen0.delete();
      for (int i = 0; i < 8; i++) begin
         s_valid[0] = 1'b1; s_op[0] = 3'(i);
         s_a[0] = 32'hF0F0_F0F0; s_b[0] = 32'hFF00_FF00;
         applyStimulus();
      end
      setIdle();
      repeat (3) applyStimulus();
      checkOutput("eight count", seen0.size(), 32'd8);
      for (int i = 0; i < 8 && i < seen0.size(); i++)
         checkOutput($sformatf("eight op%0d", i), seen0[i], eight_exp[i]);

      // Backpressure: fill the pipe, then stall for several cycles
      s_rdy[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         s_valid[0] = 1'b1; s_op[0] = 3'($urandom_range(0, 7));
         s_a[0] = $urandom; s_b[0] = $urandom;
         applyStimulus();
      end
      setIdle();
      repeat (4) applyStimulus();
      checkOutput("bp count == accepted", {16'd0, bus0.op_count}, accepted[0]);

      // Reset with two transactions in flight
      seen0.delete();
      s_rdy[0] = 1'b0;
      s_valid[0] = 1'b1; s_op[0] = 3'b001;
      applyStimulus();
      s_op[0] = 3'b010;
      applyStimulus();
      setIdle();
      s_rdy[0] = 1'b0;
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkCleared("midreset");
      setIdle();
      repeat (4) applyStimulus();
      checkOutput("midreset emerged", seen0.size(), 32'd0);

      // Narrow single-stage unit: OR with parity, then counter wrap
      s_valid[1] = 1'b1; s_op[1] = 3'b010; s_a[1] = 32'h01; s_b[1] = 32'h02;
      applyStimulus();
      setIdle();
      checkOutput("n8 valid",  {31'd0, bus1.out_valid}, 32'd1);
      checkOutput("n8 result", {24'd0, bus1.out_result}, 32'h03);
      checkOutput("n8 parity", {31'd0, bus1.out_parity}, 32'd0);
      checkOutput("n8 zero",   {31'd0, bus1.out_zero}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         s_valid[1] = 1'b1; s_op[1] = 3'($urandom_range(0, 7));
         s_a[1] = $urandom; s_b[1] = $urandom;
         applyStimulus();
      end
      setIdle();
      repeat (3) applyStimulus();
      checkOutput("wrap op_count", {28'd0, bus1.op_count}, 32'd1);

      // Random traffic on both units with occasional resets
      for (int i = 0; i < 500; i++) begin
         for (int d = 0; d < 2; d++) begin
            s_valid[d] = ($urandom_range(0, 9) < 7);
            s_rdy[d]   = ($urandom_range(0, 3) != 0);
            s_op[d]    = 3'($urandom_range(0, 7));
            s_a[d]     = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            s_b[d]     = $urandom;
         end
         rst = ($urandom_range(0, 149) == 0);
         applyStimulus();
      end
      rst = 1'b0;
      setIdle();
      repeat (5) applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the ALU datapath.
- Generalises the fixed 32-bit inverter to N bits, eight logic operations and a configurable number of register stages.
- Uses a valid/ready handshake with backpressure.
- Also produces zero and parity flags, plus a count of completed operations, for the ALU flag/status logic.

Parameters:
N, 32, operand and result width in bits (N >= 1)
STAGES, 2, pipeline register stages from accept to result (1..4)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_a/in_b/in_op valid this cycle
in_ready  output  1  unit can accept this cycle
in_a  input  N  operand A
in_b  input  N  operand B (ignored by ops 000 and 111)
in_op  input  3  operation select
out_valid  output  1  out_result/flags valid
out_ready  input  1  downstream accepts this cycle
out_result  output  N  operation result
out_zero  output  1  1 when out_result == 0
out_parity  output  1  XOR-reduction of out_result
op_count  output  CNT_W  number of output handshakes since reset

Behaviour:
- Opcodes (computed combinationally on accepted inputs, then registered):
  - 000 NOT A (~A)
  - 001 A&B
  - 010 A|B
  - 011 A^B
  - 100 ~(A&B)
  - 101 ~(A|B)
  - 110 ~(A^B)
  - 111 PASS A
- Zero and parity are computed on the stage-1 result and travel with it.
- Pipeline: STAGES register stages. Each stage holds valid bit, result[N], zero and parity.
- Global advance signal: adv = !v[STAGES-1] || out_ready.
  - in_ready = adv, combinational from out_ready and the last-stage valid only.
- Accept: occurs when in_valid && in_ready.
  - On adv, stage 0 loads {in_valid, f(in_a,in_b,in_op), flags}.
  - On adv, stage k loads stage k-1.
  - When adv=0, all stages hold; bubbles are not compressed during a stall.
- Outputs: out_valid = v[STAGES-1]; out_result/out_zero/out_parity come from the last stage.
- Latency: with out_ready held 1, a transaction accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles after presentation.
- Throughput: one operation per cycle when out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - out_result/flags/out_valid are held stable;
  - in_ready=0;
  - no input is consumed.
- Data held in a stage with v=0 is don't-care externally but must not affect out_valid.
- op_count increments by 1 on each out_valid && out_ready edge. It wraps from 2^CNT_W-1 to 0.
- Reset (rst=1 at a clock edge):
  - all valid bits, result, flag registers and op_count are cleared to 0;
  - out_valid=0, out_result=0, out_zero=0, out_parity=0, op_count=0 after the edge.
- in_ready is 1 while rst is asserted, since the last-stage valid is 0. Any handshake in a reset cycle is discarded.
- Reset mid-operation drops all in-flight transactions; no output handshake occurs for them.
- Simultaneous output handshake and input accept in the same cycle is legal. The pipeline shifts, and op_count increments once.
- STAGES=1: the result is registered once. in_ready = !out_valid || out_ready.

Test Plan:
- N=32, STAGES=2, out_ready=1; send op 000 with A=0x0000_FFFF, then op 111 with A=0 -> out_result=0xFFFF_0000 (zero=0, parity=0) two cycles after accept, then 0x0 (zero=1), op_count=2.
- Back-to-back all eight ops, A=0xF0F0_F0F0, B=0xFF00_FF00, one per cycle -> results in order:
  - 0x0F0F0F0F, 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0;
  - 0x0FFF0FFF, 0x000F000F, 0xF00FF00F, 0xF0F0F0F0;
  - one per cycle with no gaps.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0 and out_result stable throughout. Release -> no loss or duplication; op_count equals the number of accepted transactions.
- Assert rst for 1 cycle with 2 transactions in flight -> out_valid=0, out_result=0, op_count=0 next cycle; neither transaction ever emerges.
- CNT_W=4: complete 17 transactions -> op_count reads 1.
- Parity check: N=8, STAGES=1, op 010 with A=0x01, B=0x02 -> out_result=0x03, parity=0, zero=0, valid one cycle after accept.
